// File: rtl/rot_pkg.sv
// Shared definitions for the pipelined rotator: op encodings and
// helpers that size the pipeline and map mux levels onto stages.
package rot_pkg;

  typedef enum logic [1:0] {
    ROT_OP_ROTL = 2'b00,
    ROT_OP_ROTR = 2'b01,
    ROT_OP_SHL  = 2'b10,
    ROT_OP_SHR  = 2'b11
  } rot_op_t;

  // Number of amount bits, equal to the number of mux levels.
  function automatic int log2w(input int width);
    return $clog2(width);
  endfunction

  // Level k lives in stage floor(k*STAGES/LOG2W); these return the
  // first and last level index owned by stage s.
  function automatic int first_level(input int s, input int stages, input int l2);
    return (s * l2 + stages - 1) / stages;
  endfunction

  function automatic int last_level(input int s, input int stages, input int l2);
    return ((s + 1) * l2 + stages - 1) / stages - 1;
  endfunction

endpackage

// File: rtl/rot_stage.sv
// One pipeline stage of the rotator: a contiguous run of left-shift mux
// levels followed by a register slice with valid/ready flow control.
module rot_stage
  import rot_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 4,
  parameter int LOG2W     = 5,
  parameter int FIRST_LVL = 0,
  parameter int LAST_LVL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  rot_op_t          in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LOG2W-1:0] out_amt,
  output rot_op_t          out_op,
  output logic [TAG_W-1:0] out_tag
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LOG2W-1:0] amt_q, amt_d;
  rot_op_t          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] lvl_data;

  // The stage can take a beat if it is empty or its beat leaves this cycle.
  assign in_ready = ~valid_q | out_ready;

  // Left-shift mux levels owned by this stage; right ops arrive pre-reversed.
  always_comb begin
    lvl_data = in_data;
    for (int k = FIRST_LVL; k <= LAST_LVL; k++) begin
      if (in_amt[k]) begin
        if (in_op inside {ROT_OP_SHL, ROT_OP_SHR}) begin
          lvl_data = lvl_data << (2 ** k);
        end else begin
          lvl_data = (lvl_data << (2 ** k)) | (lvl_data >> (WIDTH - 2 ** k));
        end
      end
    end
  end

  // Load a new beat when the slot is free; otherwise hold for the stall.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = lvl_data;
        amt_d  = in_amt;
        op_d   = in_op;
        tag_d  = in_tag;
      end
    end
  end

  // Stage register; reset clears everything so stale beats never appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= ROT_OP_ROTL;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_amt   = amt_q;
  assign out_op    = op_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/rot_pipe.sv
// Pipelined barrel rotator/shifter. Right operations are done as
// reverse -> left op -> reverse, so every stage only shifts left.
module rot_pipe
  import rot_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  parameter  int TAG_W  = 4,
  localparam int LOG2W  = log2w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (((WIDTH & (WIDTH - 1)) != 0) || (WIDTH < 8) || (STAGES < 1) || (STAGES > LOG2W))
  begin : g_param_check
    $error("rot_pipe: WIDTH must be a power of 2 >= 8 and STAGES in 1..log2(WIDTH)");
  end

  logic             valid_s [STAGES+1];
  logic             ready_s [STAGES+1];
  logic [WIDTH-1:0] data_s  [STAGES+1];
  logic [LOG2W-1:0] amt_s   [STAGES+1];
  rot_op_t          op_s    [STAGES+1];
  logic [TAG_W-1:0] tag_s   [STAGES+1];
  logic [WIDTH-1:0] entry_data;
  logic [WIDTH-1:0] exit_data;

  // Bit-reverse right-op operands so the stages only need left shifts.
  always_comb begin
    entry_data = in_data;
    if (in_op[0]) begin
      for (int i = 0; i < WIDTH; i++) entry_data[i] = in_data[WIDTH-1-i];
    end
  end

  assign valid_s[0]      = in_valid;
  assign data_s[0]       = entry_data;
  assign amt_s[0]        = in_amt;
  assign op_s[0]         = rot_op_t'(in_op);
  assign tag_s[0]        = in_tag;
  assign ready_s[STAGES] = out_ready;
  assign in_ready        = ready_s[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = first_level(s, STAGES, LOG2W);
    localparam int LAST  = last_level(s, STAGES, LOG2W);

    rot_stage #(
      .WIDTH    (WIDTH),
      .TAG_W    (TAG_W),
      .LOG2W    (LOG2W),
      .FIRST_LVL(FIRST),
      .LAST_LVL (LAST)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (valid_s[s]),
      .in_ready (ready_s[s]),
      .in_data  (data_s[s]),
      .in_amt   (amt_s[s]),
      .in_op    (op_s[s]),
      .in_tag   (tag_s[s]),
      .out_valid(valid_s[s+1]),
      .out_ready(ready_s[s+1]),
      .out_data (data_s[s+1]),
      .out_amt  (amt_s[s+1]),
      .out_op   (op_s[s+1]),
      .out_tag  (tag_s[s+1])
    );
  end

  // Undo the entry reversal for right ops using the op carried with the beat.
  always_comb begin
    exit_data = data_s[STAGES];
    if (op_s[STAGES] inside {ROT_OP_ROTR, ROT_OP_SHR}) begin
      for (int i = 0; i < WIDTH; i++) exit_data[i] = data_s[STAGES][WIDTH-1-i];
    end
  end

  assign out_valid = valid_s[STAGES];
  assign out_data  = exit_data;
  assign out_tag   = tag_s[STAGES];

endmodule

// File: doc/rot_pipe.md
Name: rot_pipe

Overview:
- Parametrised, pipelined barrel rotator/shifter for the hash datapath. It is the successor to the fixed 32-bit combinational rotate.
- Supports four operations: rotate-left, rotate-right, logical shift-left and logical shift-right. Data width and pipeline depth are configurable.
- Uses a valid/ready handshake with full backpressure, and carries a sideband tag so the round controller can match results to requests.
- Sits between the message-schedule/round controller and the sigma/Sigma XOR logic.

Parameters:
- WIDTH, 32: data width in bits. Must be a power of 2 and ≥ 8.
- STAGES, 2: number of pipeline register stages, range 1..LOG2W where LOG2W = clog2(WIDTH).
- TAG_W, 4: sideband tag width in bits. Passes through unmodified.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept the input beat
- in_data  in  WIDTH  operand
- in_amt  in  LOG2W  shift/rotate amount, 0..WIDTH-1
- in_op  in  2  operation: 00 ROTL, 01 ROTR, 10 SHL, 11 SHR
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous and active-low; assertion is asynchronous, deassertion is used synchronously to clk.
- Reset values: every stage valid bit = 0, out_valid = 0, out_data = 0, out_tag = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded; nothing is emitted after reset.
- Transfers: a beat transfers on the input when in_valid & in_ready, and on the output when out_valid & out_ready.
- Operation semantics, for bit i of the result:
  - ROTL: out[i] = in[(i − amt) mod WIDTH]. Matches the existing 32-bit rotate.
  - ROTR: out[i] = in[(i + amt) mod WIDTH].
  - SHL: out[i] = in[i − amt] if i ≥ amt, else 0.
  - SHR: out[i] = in[i + amt] if i + amt < WIDTH, else 0.
  - amt = 0 returns the operand unchanged for all operations.
- Datapath structure:
  - Right operations: bit-reverse the operand at entry, apply the left operation, bit-reverse again at exit.
  - The left operation is LOG2W mux levels; level k shifts by 2^k when amt[k] = 1. Vacated bits are filled with the wrapped bits (rotate) or 0 (shift).
  - Level k is placed in stage floor(k·STAGES/LOG2W).
  - Each stage registers data, amt, op, tag and valid.
- Latency: exactly STAGES cycles from input acceptance to out_valid when out_ready is held at 1. Throughput is one beat per cycle.
- Backpressure:
  - Stage s accepts a new beat when it is empty or its content moves downstream in the same cycle.
  - ready_s = ~valid_s | ready_{s+1}, with ready_{STAGES} = out_ready.
  - in_ready = ready_0. This path is combinational from out_ready; its depth is STAGES gates, which is acceptable.
- Stall: while out_valid = 1 and out_ready = 0, out_data and out_tag hold stable. With no output transfer, the pipeline absorbs at most STAGES beats before in_ready falls.
- Simultaneous events: the last stage can be drained and refilled in the same cycle, so there are no bubbles.
- Order: results emerge strictly in input order. Tags are never reordered or modified.
- Invalid parameters (WIDTH not a power of 2, or STAGES outside 1..LOG2W): elaboration-time error via a generate-time check.

Decomposition:
- Package rot_pkg holds:
  - op encodings ROT_OP_ROTL/ROTR/SHL/SHR as a 2-bit typedef rot_op_t;
  - a clog2-derived LOG2W helper function.
- Sub-module rot_stage: one register stage containing its assigned mux levels (parametrised by first/last level index) plus the valid/ready slice. rot_pipe instantiates STAGES copies in a generate loop, with bit-reversal at entry and exit.

Test Plan:
1. WIDTH=32, STAGES=2, out_ready=1. Input 0x12345678 with amt=4, one beat per op:
   - ROTL → 0x23456781
   - ROTR → 0x81234567
   - SHL → 0x23456780
   - SHR → 0x01234567
   - Each result appears exactly 2 cycles after acceptance, with its tag.
2. ROTL of 0x80000001 with amt = 0, 1, 31 → 0x80000001, 0x00000003, 0xC0000000. SHR of 0xFFFFFFFF with amt=31 → 0x00000001.
3. Stream 10 back-to-back beats with out_ready=1 → in_ready stays 1 throughout and out_valid is high for 10 consecutive cycles, tags in order.
4. Stream beats with out_ready=0 → in_ready drops after STAGES beats are held and out_data stays stable. Then raise out_ready → all beats drain in order with no loss or duplication.
5. Pulse rst_n low while 2 beats are in flight → out_valid=0 immediately and no stale beat is emitted after release.
6. WIDTH=64, STAGES=6, randomised op/amt/data with random out_ready, checked against a reference model → zero mismatches over 10k beats.
